// File: rtl/sequence_detector_param_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
package sequence_detector_param_pkg;

  localparam int SEQ_LEN_MIN = 2;
  localparam int SEQ_LEN_MAX = 8;

  localparam logic [SEQ_LEN_MAX:0] BORDER_ONE = {{SEQ_LEN_MAX{1'b0}}, 1'b1};

  // Longest proper border of a len-bit pattern held right-aligned in pat
  // (MSB of the pattern is the first bit received).
  function automatic int border_len(input logic [SEQ_LEN_MAX-1:0] pat, input int len);
    logic [SEQ_LEN_MAX:0]   m;
    logic [SEQ_LEN_MAX-1:0] mask;
    int                     best;
    best = 0;
    for (int k = 1; k < SEQ_LEN_MAX; k++) begin
      m    = (BORDER_ONE << k) - BORDER_ONE;
      mask = m[SEQ_LEN_MAX-1:0];
      if (k < len && ((pat >> (len - k)) & mask) == (pat & mask)) begin
        best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sequence_detector_param_prefix_match.sv
// Combinational prefix matcher: longest pattern prefix (up to state+1 bits)
// that ends the incoming stream of history bits followed by x.
module seq_prefix_match #(
  parameter int SEQ_LEN = 4
) (
  input  logic [SEQ_LEN-1:0]       pattern,
  input  logic [SEQ_LEN-2:0]       history,
  input  logic                     x,
  input  logic [$clog2(SEQ_LEN):0] state,
  output logic [$clog2(SEQ_LEN):0] k_new,
  output logic                     match
);

  localparam int SW = $clog2(SEQ_LEN) + 1;
  localparam logic [SEQ_LEN:0] ONE = {{SEQ_LEN{1'b0}}, 1'b1};

  logic [SEQ_LEN-1:0] window;
  logic [SEQ_LEN:0]   m;
  logic [SEQ_LEN-1:0] mask;

  // window LSB is the newest bit; the last k bits are compared against the
  // top k pattern bits, and the largest passing k wins.
  always_comb begin
    window = {history, x};
    m      = '0;
    mask   = '0;
    k_new  = '0;
    for (int k = 1; k <= SEQ_LEN; k++) begin
      m    = (ONE << k) - ONE;
      mask = m[SEQ_LEN-1:0];
      if (k <= int'(state) + 1 &&
          (window & mask) == ((pattern >> (SEQ_LEN - k)) & mask)) begin
        k_new = SW'(k);
      end
    end
  end

  assign match = (k_new == SW'(SEQ_LEN));

endmodule

// File: rtl/sequence_detector_param.sv
// Loadable serial pattern detector with Mealy match flag, overlap control
// and a saturating match counter.
module sequence_detector_param
  import sequence_detector_param_pkg::*;
#(
  parameter int                 SEQ_LEN     = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [SEQ_LEN-1:0] RST_PATTERN = 4'b0110
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     X,
  input  logic                     in_valid,
  input  logic                     overlap,
  input  logic                     load,
  input  logic [SEQ_LEN-1:0]       pattern_in,
  output logic                     Y,
  output logic [CNT_W-1:0]         match_count,
  output logic [$clog2(SEQ_LEN):0] state
);

  localparam int SW = $clog2(SEQ_LEN) + 1;
  localparam int HW = SEQ_LEN - 1;

  if (SEQ_LEN < SEQ_LEN_MIN || SEQ_LEN > SEQ_LEN_MAX) begin : g_bad_seq_len
    $error("sequence_detector_param: SEQ_LEN out of legal range");
  end

  logic [SEQ_LEN-1:0]     pattern_q;
  logic [HW-1:0]          hist_q;
  logic [SW-1:0]          k_new;
  logic                   match;
  logic [SW-1:0]          border;
  logic [SEQ_LEN_MAX-1:0] pat_ext;

  seq_prefix_match #(.SEQ_LEN(SEQ_LEN)) u_match (
    .pattern (pattern_q),
    .history (hist_q),
    .x       (X),
    .state   (state),
    .k_new   (k_new),
    .match   (match)
  );

  always_comb begin
    pat_ext              = '0;
    pat_ext[SEQ_LEN-1:0] = pattern_q;
  end

  assign border = SW'(border_len(pat_ext, SEQ_LEN));
  assign Y      = in_valid && !load && match;

  // A non-overlapping match restarts from an empty history so no bit of the
  // matched pattern can seed the next detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q   <= RST_PATTERN;
      hist_q      <= '0;
      state       <= '0;
      match_count <= '0;
    end else if (load) begin
      pattern_q   <= pattern_in;
      hist_q      <= '0;
      state       <= '0;
      match_count <= '0;
    end else if (in_valid) begin
      if (match && !overlap) begin
        state  <= '0;
        hist_q <= '0;
      end else begin
        state  <= match ? border : k_new;
        hist_q <= HW'({hist_q, X});
      end
      if (match && match_count != {CNT_W{1'b1}}) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sequence_detector_param.sv
// Directed table-driven bench for sequence_detector_param, plus a narrow
// instance exercising counter saturation.
module tb_sequence_detector_param;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       x, in_valid, overlap, load;
  logic [3:0] pattern_in;
  logic       y;
  logic [7:0] match_count;
  logic [2:0] state;

  logic       x2, valid2, overlap2, load2;
  logic [1:0] pattern_in2;
  logic       y2;
  logic [1:0] count2;
  logic [1:0] state2;

  int vecCount = 0;
  int failCount = 0;

  always #5 clock = ~clock;

  sequence_detector_param dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .X           (x),
    .in_valid    (in_valid),
    .overlap     (overlap),
    .load        (load),
    .pattern_in  (pattern_in),
    .Y           (y),
    .match_count (match_count),
    .state       (state)
  );

  sequence_detector_param #(.SEQ_LEN(2), .CNT_W(2), .RST_PATTERN(2'b11)) dut2 (
    .clock       (clock),
    .reset_n     (reset_n),
    .X           (x2),
    .in_valid    (valid2),
    .overlap     (overlap2),
    .load        (load2),
    .pattern_in  (pattern_in2),
    .Y           (y2),
    .match_count (count2),
    .state       (state2)
  );

  typedef struct {
    string      tag;
    bit         rst;
    bit         ld;
    bit         vld;
    bit         xb;
    bit         ovl;
    logic [3:0] pat;
    bit         y;
    logic [2:0] st;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string tag, input bit rst, input bit ld, input bit vld,
                        input bit xb, input bit ovl, input logic [3:0] pat, input bit ye,
                        input logic [2:0] st, input logic [7:0] cnt);
    vec_t v;
    v.tag = tag; v.rst = rst; v.ld = ld; v.vld = vld; v.xb = xb; v.ovl = ovl;
    v.pat = pat; v.y = ye; v.st = st; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reset is asserted between clock edges so the checks see its asynchronous effect.
  task automatic applyReset(input string tag);
    @(negedge clock);
    in_valid = 1'b0; load = 1'b0; valid2 = 1'b0; load2 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput({tag, "/rst_state"}, 32'(state), 32'd0);
    checkOutput({tag, "/rst_count"}, 32'(match_count), 32'd0);
    checkOutput({tag, "/rst_y"}, 32'(y), 32'd0);
    checkOutput({tag, "/rst_state2"}, 32'(state2), 32'd0);
    checkOutput({tag, "/rst_count2"}, 32'(count2), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rst) begin
      applyReset(v.tag);
    end else begin
      @(negedge clock);
      load = v.ld; in_valid = v.vld; x = v.xb; overlap = v.ovl; pattern_in = v.pat;
      #1;
      checkOutput({v.tag, "/Y"}, 32'(y), 32'(v.y));
      @(posedge clock);
      #1;
      checkOutput({v.tag, "/state"}, 32'(state), 32'(v.st));
      checkOutput({v.tag, "/count"}, 32'(match_count), 32'(v.cnt));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    x = 1'b0; in_valid = 1'b0; overlap = 1'b1; load = 1'b0; pattern_in = 4'b0000;
    x2 = 1'b0; valid2 = 1'b0; overlap2 = 1'b1; load2 = 1'b0; pattern_in2 = 2'b00;

    //      tag    rst ld vld x ovl pat      y  st cnt
    addVec("A0",   1, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
    addVec("A1",   0, 0, 1, 0, 1, 4'b0000, 0, 1, 0);
    addVec("A2",   0, 0, 1, 1, 1, 4'b0000, 0, 2, 0);
    addVec("A3",   0, 0, 1, 1, 1, 4'b0000, 0, 3, 0);
    addVec("A4",   0, 0, 1, 0, 1, 4'b0000, 1, 1, 1);
    addVec("A5",   0, 0, 1, 1, 1, 4'b0000, 0, 2, 1);
    addVec("A6",   0, 0, 1, 1, 1, 4'b0000, 0, 3, 1);
    addVec("A7",   0, 0, 1, 0, 1, 4'b0000, 1, 1, 2);
    addVec("B0",   1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    addVec("B1",   0, 0, 1, 0, 0, 4'b0000, 0, 1, 0);
    addVec("B2",   0, 0, 1, 1, 0, 4'b0000, 0, 2, 0);
    addVec("B3",   0, 0, 1, 1, 0, 4'b0000, 0, 3, 0);
    addVec("B4",   0, 0, 1, 0, 0, 4'b0000, 1, 0, 1);
    addVec("B5",   0, 0, 1, 1, 0, 4'b0000, 0, 0, 1);
    addVec("B6",   0, 0, 1, 1, 0, 4'b0000, 0, 0, 1);
    addVec("B7",   0, 0, 1, 0, 0, 4'b0000, 0, 1, 1);
    addVec("B8",   0, 0, 1, 0, 0, 4'b0000, 0, 1, 1);
    addVec("B9",   0, 0, 1, 1, 0, 4'b0000, 0, 2, 1);
    addVec("B10",  0, 0, 1, 1, 0, 4'b0000, 0, 3, 1);
    addVec("B11",  0, 0, 1, 0, 0, 4'b0000, 1, 0, 2);
    addVec("C0",   1, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
    addVec("C1",   0, 0, 1, 0, 1, 4'b0000, 0, 1, 0);
    addVec("C2",   0, 0, 1, 1, 1, 4'b0000, 0, 2, 0);
    addVec("C3",   0, 0, 0, 1, 1, 4'b0000, 0, 2, 0);
    addVec("C4",   0, 0, 0, 0, 1, 4'b0000, 0, 2, 0);
    addVec("C5",   0, 0, 0, 1, 1, 4'b0000, 0, 2, 0);
    addVec("C6",   0, 0, 1, 1, 1, 4'b0000, 0, 3, 0);
    addVec("C7",   0, 0, 0, 0, 1, 4'b0000, 0, 3, 0);
    addVec("C8",   0, 0, 1, 0, 1, 4'b0000, 1, 1, 1);
    addVec("D1",   0, 0, 1, 1, 1, 4'b0000, 0, 2, 1);
    addVec("D2",   0, 0, 1, 0, 1, 4'b0000, 0, 1, 1);
    addVec("D3",   0, 0, 1, 1, 1, 4'b0000, 0, 2, 1);
    addVec("D4",   0, 0, 1, 1, 1, 4'b0000, 0, 3, 1);
    addVec("D5",   0, 1, 1, 0, 1, 4'b1011, 0, 0, 0);
    addVec("D6",   0, 0, 1, 1, 1, 4'b1011, 0, 1, 0);
    addVec("D7",   0, 0, 1, 0, 1, 4'b1011, 0, 2, 0);
    addVec("D8",   0, 0, 1, 1, 1, 4'b1011, 0, 3, 0);
    addVec("D9",   0, 0, 1, 1, 1, 4'b1011, 1, 1, 1);
    addVec("D10",  0, 0, 1, 0, 1, 4'b1011, 0, 2, 1);
    addVec("D11",  0, 0, 1, 1, 1, 4'b1011, 0, 3, 1);
    addVec("D12",  0, 0, 1, 1, 0, 4'b1011, 1, 0, 2);
    addVec("E1",   0, 0, 1, 0, 1, 4'b0000, 0, 0, 2);
    addVec("E2",   0, 0, 1, 1, 1, 4'b0000, 0, 1, 2);
    addVec("E3",   0, 0, 1, 1, 1, 4'b0000, 0, 1, 2);
    addVec("E_rst",1, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
    addVec("E4",   0, 0, 1, 0, 1, 4'b0000, 0, 1, 0);
    addVec("E5",   0, 0, 1, 1, 1, 4'b0000, 0, 2, 0);
    addVec("E6",   0, 0, 1, 1, 1, 4'b0000, 0, 3, 0);
    addVec("E7",   0, 0, 1, 0, 1, 4'b0000, 1, 1, 1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Two-bit pattern 11, overlapping, on a 2-bit counter: saturation at 3.
    applyReset("S_rst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      in_valid = 1'b0; valid2 = 1'b1; x2 = 1'b1; overlap2 = 1'b1;
      #1;
      checkOutput($sformatf("S%0d/Y", i + 1), 32'(y2), (i >= 1) ? 32'd1 : 32'd0);
      @(posedge clock);
      #1;
      checkOutput($sformatf("S%0d/count", i + 1), 32'(count2), (i > 3) ? 32'd3 : 32'(i));
      checkOutput($sformatf("S%0d/state", i + 1), 32'(state2), 32'd1);
    end
    @(negedge clock);
    valid2 = 1'b0;
    #1;
    checkOutput("S_idle/Y", 32'(y2), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("S_idle/count", 32'(count2), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
